// File: rtl/pomodoro_sequencer.sv
// Pomodoro phase sequencer: debounced-free button edges drive an IDLE/RUN/PAUSE
// controller that counts a BCD MM:SS value down through WORK/SHORT/LONG phases.
`timescale 1ns/1ps
module pomodoro_sequencer #(
  parameter int unsigned CLK_TICKS_PER_SEC  = 50_000_000,
  parameter int unsigned WORK_MIN           = 25,
  parameter int unsigned SHORT_MIN          = 5,
  parameter int unsigned LONG_MIN           = 15,
  parameter int unsigned CYCLES_BEFORE_LONG = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn,
  output logic [15:0] displayed_number,
  output logic [1:0]  phase,
  output logic        running,
  output logic        phase_done,
  output logic [3:0]  work_count
);

  localparam int unsigned PW = (CLK_TICKS_PER_SEC > 1) ? $clog2(CLK_TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_TICKS_PER_SEC - 1);
  localparam logic [7:0] WORK_BCD  = 8'((WORK_MIN / 10) * 16 + (WORK_MIN % 10));
  localparam logic [7:0] SHORT_BCD = 8'((SHORT_MIN / 10) * 16 + (SHORT_MIN % 10));
  localparam logic [7:0] LONG_BCD  = 8'((LONG_MIN / 10) * 16 + (LONG_MIN % 10));
  localparam logic [3:0] LAST_WORK = 4'(CYCLES_BEFORE_LONG - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2} state_e;
  typedef enum logic [1:0] {PH_WORK = 2'd0, PH_SHORT = 2'd1, PH_LONG = 2'd2} phase_e;

  state_e        state_q, state_d;
  phase_e        phase_q, phase_d, adv_phase_c;
  logic [15:0]   time_q, time_d, adv_time_c;
  logic [3:0]    wc_q, wc_d, adv_wc_c;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic          running_q;
  logic [3:0]    sync1_q, sync2_q, prev_q;
  logic [3:0]    edge_c;
  logic          clr_c, skip_c, start_c, inc_c;

  // One-second BCD countdown step; caller guarantees time is not 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = t;
    if (su != 4'd0) su = su - 4'd1;
    else begin
      su = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mu != 4'd0) mu = mu - 4'd1;
        else begin
          mu = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  function automatic logic [7:0] bcd_inc_min(input logic [7:0] m);
    if (m == 8'h99)             return m;
    else if (m[3:0] == 4'd9)    return {m[7:4] + 4'd1, 4'd0};
    else                        return {m[7:4], m[3:0] + 4'd1};
  endfunction

  // Button synchroniser and rising-edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 4'd0;
      sync2_q <= 4'd0;
      prev_q  <= 4'd0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_c  = sync2_q & ~prev_q;
  assign clr_c   = edge_c[1];
  assign skip_c  = edge_c[2] & ~clr_c;
  assign start_c = edge_c[3] & ~clr_c & ~skip_c;
  assign inc_c   = edge_c[0] & ~clr_c & ~skip_c & ~start_c;

  // Next phase, set counter and load value shared by expiry and skip
  always_comb begin
    adv_phase_c = PH_WORK;
    adv_wc_c    = wc_q;
    adv_time_c  = {WORK_BCD, 8'h00};
    if (phase_q == PH_WORK) begin
      if (wc_q == LAST_WORK) begin
        adv_phase_c = PH_LONG;
        adv_wc_c    = 4'd0;
        adv_time_c  = {LONG_BCD, 8'h00};
      end else begin
        adv_phase_c = PH_SHORT;
        adv_wc_c    = wc_q + 4'd1;
        adv_time_c  = {SHORT_BCD, 8'h00};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    time_d  = time_q;
    wc_d    = wc_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    if (clr_c) begin
      state_d = S_IDLE;
      phase_d = PH_WORK;
      time_d  = {WORK_BCD, 8'h00};
      wc_d    = 4'd0;
      presc_d = '0;
    end else if (skip_c) begin
      phase_d = adv_phase_c;
      time_d  = adv_time_c;
      wc_d    = adv_wc_c;
      presc_d = '0;
      if (state_q == S_PAUSE) state_d = S_IDLE;
    end else if (start_c) begin
      // The toggle cycle itself does not advance the prescaler
      state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
    end else if (state_q == S_RUN) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        if (time_q == 16'h0000) begin
          done_d  = 1'b1;
          phase_d = adv_phase_c;
          time_d  = adv_time_c;
          wc_d    = adv_wc_c;
        end else begin
          time_d = bcd_dec(time_q);
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else if (inc_c) begin
      time_d = {bcd_inc_min(time_q[15:8]), time_q[7:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= PH_WORK;
      time_q    <= {WORK_BCD, 8'h00};
      wc_q      <= 4'd0;
      presc_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      time_q    <= time_d;
      wc_q      <= wc_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      running_q <= (state_d == S_RUN);
    end
  end

  assign displayed_number = time_q;
  assign phase            = phase_q;
  assign running          = running_q;
  assign phase_done       = done_q;
  assign work_count       = wc_q;

endmodule

// File: tb/tb_pomodoro_sequencer.sv
// Scoreboard bench: stimulus queues hand-computed expectations tagged with a
// cycle number; a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_pomodoro_sequencer;

  logic        clk;
  logic        rst;
  logic [3:0]  btn;
  logic [15:0] displayed_number;
  logic [1:0]  phase;
  logic        running;
  logic        phase_done;
  logic [3:0]  work_count;

  pomodoro_sequencer #(
    .CLK_TICKS_PER_SEC (2),
    .WORK_MIN          (1),
    .SHORT_MIN         (2),
    .LONG_MIN          (3),
    .CYCLES_BEFORE_LONG(2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .btn             (btn),
    .displayed_number(displayed_number),
    .phase           (phase),
    .running         (running),
    .phase_done      (phase_done),
    .work_count      (work_count)
  );

  typedef struct {
    int          cyc;
    int          id;
    logic [15:0] disp;
    logic [1:0]  ph;
    logic        run;
    logic        pd;
    logic [3:0]  wc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   b = 0;
  int   next_id = 0;
  int   checks = 0;
  int   failures = 0;
  int   pd_count = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic exp_at(input int n, input logic [15:0] d, input logic [1:0] ph,
                        input logic run, input logic pd, input logic [3:0] wc);
    exp_t x;
    x.cyc = b + n; x.id = next_id; x.disp = d; x.ph = ph; x.run = run; x.pd = pd; x.wc = wc;
    q.push_back(x);
    next_id++;
  endtask

  task automatic go(input int n);
    while (cyc < b + n) @(negedge clk);
  endtask

  // Monitor: compare every expectation due at this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL chk%0d missed: sampled at cycle %0d, required cycle %0d", e.id, cyc, e.cyc);
      end else if ({displayed_number, phase, running, phase_done, work_count} !==
                   {e.disp, e.ph, e.run, e.pd, e.wc}) begin
        failures++;
        $display("FAIL chk%0d cyc=%0d got disp=%h ph=%0d run=%b pd=%b wc=%0d required disp=%h ph=%0d run=%b pd=%b wc=%0d",
                 e.id, cyc, displayed_number, phase, running, phase_done, work_count,
                 e.disp, e.ph, e.run, e.pd, e.wc);
      end
    end
    if (!rst && phase_done === 1'b1) pd_count++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d, required completion", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    btn = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state, no counting in IDLE
    b = cyc;
    exp_at(1, 16'h0100, 2'd0, 1'b0, 1'b0, 4'd0);
    exp_at(5, 16'h0100, 2'd0, 1'b0, 1'b0, 4'd0);
    go(7);

    // Start latency, held start, pause with prescaler hold, +1 in PAUSE and RUN
    b = cyc;
    exp_at(2,   16'h0100, 2'd0, 1'b0, 1'b0, 4'd0);
    exp_at(3,   16'h0100, 2'd0, 1'b1, 1'b0, 4'd0);
    exp_at(4,   16'h0100, 2'd0, 1'b1, 1'b0, 4'd0);
    exp_at(5,   16'h0059, 2'd0, 1'b1, 1'b0, 4'd0);
    exp_at(12,  16'h0056, 2'd0, 1'b1, 1'b0, 4'd0);
    exp_at(23,  16'h0050, 2'd0, 1'b1, 1'b0, 4'd0);
    exp_at(25,  16'h0050, 2'd0, 1'b0, 1'b0, 4'd0);
    exp_at(125, 16'h0050, 2'd0, 1'b0, 1'b0, 4'd0);
    exp_at(129, 16'h0150, 2'd0, 1'b0, 1'b0, 4'd0);
    exp_at(138, 16'h0150, 2'd0, 1'b1, 1'b0, 4'd0);
    exp_at(139, 16'h0149, 2'd0, 1'b1, 1'b0, 4'd0);
    exp_at(145, 16'h0146, 2'd0, 1'b1, 1'b0, 4'd0);
    go(0);   btn = 4'b1000;
    go(10);  btn = 4'b0000;
    go(22);  btn = 4'b1000;
    go(26);  btn = 4'b0000;
    go(126); btn = 4'b0001;
    go(131); btn = 4'b0000;
    go(135); btn = 4'b1000;
    go(140); btn = 4'b0000;
    go(141); btn = 4'b0001;
    go(146); btn = 4'b0000;
    go(147);

    // Clear and start/pause together in RUN, held 50 cycles: clear wins once
    b = cyc;
    exp_at(3,  16'h0100, 2'd0, 1'b0, 1'b0, 4'd0);
    exp_at(8,  16'h0100, 2'd0, 1'b0, 1'b0, 4'd0);
    exp_at(55, 16'h0100, 2'd0, 1'b0, 1'b0, 4'd0);
    go(0);  btn = 4'b1010;
    go(50); btn = 4'b0000;
    go(57);

    // Skip x4 from IDLE: WORK->SHORT->WORK->LONG->WORK
    b = cyc;
    exp_at(2,  16'h0100, 2'd0, 1'b0, 1'b0, 4'd0);
    exp_at(3,  16'h0200, 2'd1, 1'b0, 1'b0, 4'd1);
    exp_at(11, 16'h0100, 2'd0, 1'b0, 1'b0, 4'd1);
    exp_at(19, 16'h0300, 2'd2, 1'b0, 1'b0, 4'd0);
    exp_at(27, 16'h0100, 2'd0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      go(8 * i);     btn = 4'b0100;
      go(8 * i + 4); btn = 4'b0000;
    end
    go(29);

    // Natural expiry, skip in RUN, pause, skip from PAUSE, clear
    b = cyc;
    exp_at(3,   16'h0100, 2'd0, 1'b1, 1'b0, 4'd0);
    exp_at(123, 16'h0000, 2'd0, 1'b1, 1'b0, 4'd0);
    exp_at(124, 16'h0000, 2'd0, 1'b1, 1'b0, 4'd0);
    exp_at(125, 16'h0200, 2'd1, 1'b1, 1'b1, 4'd1);
    exp_at(126, 16'h0200, 2'd1, 1'b1, 1'b0, 4'd1);
    exp_at(127, 16'h0159, 2'd1, 1'b1, 1'b0, 4'd1);
    exp_at(131, 16'h0100, 2'd0, 1'b1, 1'b0, 4'd1);
    exp_at(133, 16'h0059, 2'd0, 1'b1, 1'b0, 4'd1);
    exp_at(139, 16'h0057, 2'd0, 1'b0, 1'b0, 4'd1);
    exp_at(145, 16'h0300, 2'd2, 1'b0, 1'b0, 4'd0);
    exp_at(153, 16'h0100, 2'd0, 1'b0, 1'b0, 4'd0);
    go(0);   btn = 4'b1000;
    go(4);   btn = 4'b0000;
    go(128); btn = 4'b0100;
    go(132); btn = 4'b0000;
    go(136); btn = 4'b1000;
    go(140); btn = 4'b0000;
    go(142); btn = 4'b0100;
    go(146); btn = 4'b0000;
    go(150); btn = 4'b0010;
    go(154); btn = 4'b0000;
    go(156);

    // +1 min to saturation at 99, then borrow chain 99:00 -> 97:59
    b = cyc;
    exp_at(3,   16'h0200, 2'd0, 1'b0, 1'b0, 4'd0);
    exp_at(67,  16'h1000, 2'd0, 1'b0, 1'b0, 4'd0);
    exp_at(75,  16'h1100, 2'd0, 1'b0, 1'b0, 4'd0);
    exp_at(779, 16'h9900, 2'd0, 1'b0, 1'b0, 4'd0);
    exp_at(787, 16'h9900, 2'd0, 1'b0, 1'b0, 4'd0);
    exp_at(805, 16'h9859, 2'd0, 1'b1, 1'b0, 4'd0);
    exp_at(823, 16'h9850, 2'd0, 1'b1, 1'b0, 4'd0);
    exp_at(825, 16'h9849, 2'd0, 1'b1, 1'b0, 4'd0);
    exp_at(923, 16'h9800, 2'd0, 1'b1, 1'b0, 4'd0);
    exp_at(925, 16'h9759, 2'd0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 99; i++) begin
      go(8 * i);     btn = 4'b0001;
      go(8 * i + 4); btn = 4'b0000;
    end
    go(800); btn = 4'b1000;
    go(804); btn = 4'b0000;
    go(927);

    // Async reset between clock edges while running
    b = cyc;
    exp_at(1,  16'h0100, 2'd0, 1'b0, 1'b0, 4'd0);
    exp_at(4,  16'h0100, 2'd0, 1'b0, 1'b0, 4'd0);
    exp_at(12, 16'h0100, 2'd0, 1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    go(3);
    rst = 1'b0;
    go(14);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations got %0d required 0", q.size());
    end
    checks++;
    if (pd_count != 1) begin
      failures++;
      $display("FAIL phase_done_pulses got %0d required 1", pd_count);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
